// File: rtl/max7219_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : max7219_pkg
//  Description : Shared constants, frame layout and helpers for the MAX7219
//                serial-port receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package max7219_pkg;

    localparam int C_MAX7219_FRAME_W = 16;
    localparam int C_BIT_CNT_W       = 5;

    localparam logic [C_BIT_CNT_W-1:0] C_BIT_CNT_MAX = 5'd31;
    localparam logic [C_BIT_CNT_W-1:0] C_BIT_CNT_MIN_FRAME = 5'd16;

    localparam logic [3:0] C_MAX7219_ADDR_NOOP         = 4'h0;
    localparam logic [3:0] C_MAX7219_ADDR_DIGIT0       = 4'h1;
    localparam logic [3:0] C_MAX7219_ADDR_DIGIT1       = 4'h2;
    localparam logic [3:0] C_MAX7219_ADDR_DIGIT2       = 4'h3;
    localparam logic [3:0] C_MAX7219_ADDR_DIGIT3       = 4'h4;
    localparam logic [3:0] C_MAX7219_ADDR_DIGIT4       = 4'h5;
    localparam logic [3:0] C_MAX7219_ADDR_DIGIT5       = 4'h6;
    localparam logic [3:0] C_MAX7219_ADDR_DIGIT6       = 4'h7;
    localparam logic [3:0] C_MAX7219_ADDR_DIGIT7       = 4'h8;
    localparam logic [3:0] C_MAX7219_ADDR_DECODE       = 4'h9;
    localparam logic [3:0] C_MAX7219_ADDR_INTENSITY    = 4'hA;
    localparam logic [3:0] C_MAX7219_ADDR_SCAN_LIMIT   = 4'hB;
    localparam logic [3:0] C_MAX7219_ADDR_SHUTDOWN     = 4'hC;
    localparam logic [3:0] C_MAX7219_ADDR_DISPLAY_TEST = 4'hF;

    typedef struct packed {
        logic [3:0] unused;
        logic [3:0] addr;
        logic [7:0] data;
    } t_max7219_frame;

    // Digit registers are addressed 1..8; map to a 0-based slot number.
    function automatic logic [2:0] max7219_digit_index(input logic [3:0] addr);
        logic [3:0] w_idx;
        w_idx = addr - 4'd1;
        return w_idx[2:0];
    endfunction

endpackage : max7219_pkg
`default_nettype wire

// File: rtl/max7219_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : max7219_sync_edge
//  Description : Multi-stage synchronizer with registered-level rise/fall
//                detection for one asynchronous serial pin.
//  Revision    : 1.0 - initial release
// ============================================================================
module max7219_sync_edge #(
    parameter int G_SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_level_d,
    output logic o_rise,
    output logic o_fall
);

    logic [G_SYNC_STAGES-1:0] r_sync;
    logic                     r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[G_SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[G_SYNC_STAGES-1];
        end
    end

    assign o_level   = r_sync[G_SYNC_STAGES-1];
    assign o_level_d = r_prev;
    assign o_rise    = r_sync[G_SYNC_STAGES-1] & ~r_prev;
    assign o_fall    = ~r_sync[G_SYNC_STAGES-1] & r_prev;

endmodule : max7219_sync_edge
`default_nettype wire

// File: rtl/max7219_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : max7219_frame_rx
//  Description : Device-side MAX7219 serial receiver: oversampled shift
//                register, LOAD-edge commit into a register file, daisy DOUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module max7219_frame_rx
    import max7219_pkg::*;
#(
    parameter int G_SYNC_STAGES = 2,
    parameter int G_DOUT_EN     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_max7219_clk,
    input  logic        i_max7219_din,
    input  logic        i_max7219_load,
    output logic        o_max7219_dout,
    output logic        o_frame_valid,
    output logic [3:0]  o_frame_addr,
    output logic [7:0]  o_frame_data,
    output logic        o_frame_err,
    output logic [63:0] o_digit_regs,
    output logic [7:0]  o_decode_mode,
    output logic [3:0]  o_intensity,
    output logic [2:0]  o_scan_limit,
    output logic        o_shutdown_n,
    output logic        o_display_test
);

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_sclk_lvl_unused;
    logic w_sclk_lvl_d_unused;
    logic w_din;
    logic w_din_lvl_d_unused;
    logic w_din_rise_unused;
    logic w_din_fall_unused;
    logic w_load_lvl;
    logic w_load_lvl_d;
    logic w_load_rise;
    logic w_load_fall_unused;

    max7219_sync_edge #(.G_SYNC_STAGES(G_SYNC_STAGES)) u_sync_clk (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_async   (i_max7219_clk),
        .o_level   (w_sclk_lvl_unused),
        .o_level_d (w_sclk_lvl_d_unused),
        .o_rise    (w_sclk_rise),
        .o_fall    (w_sclk_fall)
    );

    max7219_sync_edge #(.G_SYNC_STAGES(G_SYNC_STAGES)) u_sync_din (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_async   (i_max7219_din),
        .o_level   (w_din),
        .o_level_d (w_din_lvl_d_unused),
        .o_rise    (w_din_rise_unused),
        .o_fall    (w_din_fall_unused)
    );

    max7219_sync_edge #(.G_SYNC_STAGES(G_SYNC_STAGES)) u_sync_load (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_async   (i_max7219_load),
        .o_level   (w_load_lvl),
        .o_level_d (w_load_lvl_d),
        .o_rise    (w_load_rise),
        .o_fall    (w_load_fall_unused)
    );

    logic [C_MAX7219_FRAME_W-1:0] r_sr;
    logic [C_BIT_CNT_W-1:0]       r_bit_cnt;
    logic [C_MAX7219_FRAME_W-1:0] w_sr_next;
    logic [C_BIT_CNT_W-1:0]       w_cnt_next;
    logic                         w_load_high;
    logic                         w_shift;
    logic                         w_commit;
    logic                         w_err;
    logic [2:0]                   w_digit_idx;
    t_max7219_frame               w_frame;
    logic                         w_unused_nibble;

    // Load counts as high only once it has been high for two samples, so an
    // edge coinciding with the load transition still shifts.
    assign w_load_high = w_load_lvl & w_load_lvl_d;
    assign w_shift     = w_sclk_rise & ~w_load_high;
    assign w_commit    = w_load_rise;

    always_comb begin
        w_sr_next  = r_sr;
        w_cnt_next = r_bit_cnt;
        if (w_shift) begin
            w_sr_next = {r_sr[C_MAX7219_FRAME_W-2:0], w_din};
            if (r_bit_cnt != C_BIT_CNT_MAX) begin
                w_cnt_next = r_bit_cnt + 5'd1;
            end
        end
    end

    assign w_frame         = t_max7219_frame'(w_sr_next);
    assign w_err           = (w_cnt_next < C_BIT_CNT_MIN_FRAME);
    assign w_digit_idx     = max7219_digit_index(w_frame.addr);
    assign w_unused_nibble = ^w_frame.unused;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr      <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_sr      <= w_sr_next;
            r_bit_cnt <= w_commit ? '0 : w_cnt_next;
        end
    end

    logic       r_frame_valid;
    logic [3:0] r_frame_addr;
    logic [7:0] r_frame_data;
    logic       r_frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_valid <= 1'b0;
            r_frame_addr  <= '0;
            r_frame_data  <= '0;
            r_frame_err   <= 1'b0;
        end else begin
            r_frame_valid <= w_commit;
            if (w_commit) begin
                r_frame_addr <= w_frame.addr;
                r_frame_data <= w_frame.data;
                r_frame_err  <= w_err;
            end
        end
    end

    logic [63:0] r_digit_regs;
    logic [7:0]  r_decode_mode;
    logic [3:0]  r_intensity;
    logic [2:0]  r_scan_limit;
    logic        r_shutdown_n;
    logic        r_display_test;

    // No-op, 0xD and 0xE fall through to default and only produce the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit_regs   <= '0;
            r_decode_mode  <= '0;
            r_intensity    <= '0;
            r_scan_limit   <= '0;
            r_shutdown_n   <= 1'b0;
            r_display_test <= 1'b0;
        end else if (w_commit && !w_err) begin
            case (w_frame.addr)
                C_MAX7219_ADDR_DIGIT0, C_MAX7219_ADDR_DIGIT1,
                C_MAX7219_ADDR_DIGIT2, C_MAX7219_ADDR_DIGIT3,
                C_MAX7219_ADDR_DIGIT4, C_MAX7219_ADDR_DIGIT5,
                C_MAX7219_ADDR_DIGIT6, C_MAX7219_ADDR_DIGIT7:
                    r_digit_regs[{w_digit_idx, 3'b000} +: 8] <= w_frame.data;
                C_MAX7219_ADDR_DECODE:       r_decode_mode  <= w_frame.data;
                C_MAX7219_ADDR_INTENSITY:    r_intensity    <= w_frame.data[3:0];
                C_MAX7219_ADDR_SCAN_LIMIT:   r_scan_limit   <= w_frame.data[2:0];
                C_MAX7219_ADDR_SHUTDOWN:     r_shutdown_n   <= w_frame.data[0];
                C_MAX7219_ADDR_DISPLAY_TEST: r_display_test <= w_frame.data[0];
                default: ;
            endcase
        end
    end

    generate
        if (G_DOUT_EN != 0) begin : g_dout
            logic r_dout;

            // Updating on the falling edge gives the next device a full
            // half-period of setup before its rising-edge sample.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout <= 1'b0;
                end else if (w_sclk_fall && !w_load_high) begin
                    r_dout <= r_sr[C_MAX7219_FRAME_W-1];
                end
            end

            assign o_max7219_dout = r_dout;
        end else begin : g_no_dout
            assign o_max7219_dout = 1'b0;
        end
    endgenerate

    assign o_frame_valid  = r_frame_valid;
    assign o_frame_addr   = r_frame_addr;
    assign o_frame_data   = r_frame_data;
    assign o_frame_err    = r_frame_err;
    assign o_digit_regs   = r_digit_regs;
    assign o_decode_mode  = r_decode_mode;
    assign o_intensity    = r_intensity;
    assign o_scan_limit   = r_scan_limit;
    assign o_shutdown_n   = r_shutdown_n;
    assign o_display_test = r_display_test;

endmodule : max7219_frame_rx
`default_nettype wire

// File: tb/tb_max7219_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_max7219_frame_rx
//  Description : Scoreboard bench for two cascaded max7219_frame_rx devices.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_max7219_frame_rx;

    localparam int SYNC = 2;
    localparam int HP   = 4;

    logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, din = 1'b0, load = 1'b0;

    logic        n_dout, n_valid, n_err, n_shdn, n_dtest;
    logic [3:0]  n_addr, n_inten;
    logic [7:0]  n_data, n_dec;
    logic [63:0] n_dig;
    logic [2:0]  n_scan;
    logic        f_dout, f_valid, f_err, f_shdn, f_dtest;
    logic [3:0]  f_addr, f_inten;
    logic [7:0]  f_data, f_dec;
    logic [63:0] f_dig;
    logic [2:0]  f_scan;

    always #5 clk = ~clk;

    max7219_frame_rx #(.G_SYNC_STAGES(SYNC), .G_DOUT_EN(1)) u_near (
        .clk(clk), .rst_n(rst_n),
        .i_max7219_clk(sclk), .i_max7219_din(din), .i_max7219_load(load),
        .o_max7219_dout(n_dout), .o_frame_valid(n_valid), .o_frame_addr(n_addr),
        .o_frame_data(n_data), .o_frame_err(n_err), .o_digit_regs(n_dig),
        .o_decode_mode(n_dec), .o_intensity(n_inten), .o_scan_limit(n_scan),
        .o_shutdown_n(n_shdn), .o_display_test(n_dtest)
    );

    max7219_frame_rx #(.G_SYNC_STAGES(SYNC), .G_DOUT_EN(1)) u_far (
        .clk(clk), .rst_n(rst_n),
        .i_max7219_clk(sclk), .i_max7219_din(n_dout), .i_max7219_load(load),
        .o_max7219_dout(f_dout), .o_frame_valid(f_valid), .o_frame_addr(f_addr),
        .o_frame_data(f_data), .o_frame_err(f_err), .o_digit_regs(f_dig),
        .o_decode_mode(f_dec), .o_intensity(f_inten), .o_scan_limit(f_scan),
        .o_shutdown_n(f_shdn), .o_display_test(f_dtest)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [7:0]  data;
        logic        err;
        logic [63:0] dig;
        logic [7:0]  dec;
        logic [3:0]  inten;
        logic [2:0]  scan;
        logic        shdn;
        logic        dtest;
    } exp_t;

    exp_t mdl [2];
    exp_t q_near[$];
    exp_t q_far[$];
    bit   hist_n[$];
    bit   hist_f[$];
    int   cnt_n, cnt_f;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every device powers up (and resets) with an all-zero shift register.
    task automatic model_reset();
        for (int d = 0; d < 2; d++) mdl[d] = '{default: '0};
        hist_n.delete();
        hist_f.delete();
        repeat (16) begin
            hist_n.push_back(1'b0);
            hist_f.push_back(1'b0);
        end
        cnt_n = 0;
        cnt_f = 0;
    endtask

    function automatic logic [15:0] last16(input bit q[$]);
        logic [15:0] w = '0;
        for (int i = q.size() - 16; i < q.size(); i++) w = {w[14:0], q[i]};
        return w;
    endfunction

    task automatic commit_dev(input int d, input int n, input logic [15:0] w);
        exp_t e;
        int   idx;
        e      = mdl[d];
        e.err  = (n < 16);
        e.addr = w[11:8];
        e.data = w[7:0];
        if (!e.err) begin
            case (e.addr)
                4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
                    idx = (int'(e.addr) - 1) * 8;
                    e.dig[idx +: 8] = e.data;
                end
                4'h9: e.dec   = e.data;
                4'hA: e.inten = e.data[3:0];
                4'hB: e.scan  = e.data[2:0];
                4'hC: e.shdn  = e.data[0];
                4'hF: e.dtest = e.data[0];
                default: ;
            endcase
        end
        mdl[d] = e;
        if (d == 0) q_near.push_back(e);
        else        q_far.push_back(e);
    endtask

    // Far device sees the bit that left the near device 16 shifts earlier.
    task automatic shift_bit(input bit b);
        din = b;
        tick(HP);
        sclk = 1'b1;
        hist_f.push_back(hist_n[hist_n.size() - 16]);
        hist_n.push_back(b);
        cnt_n++;
        cnt_f++;
        if (hist_n.size() > 32) void'(hist_n.pop_front());
        if (hist_f.size() > 32) void'(hist_f.pop_front());
        tick(HP);
        sclk = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
    endtask

    task automatic do_load();
        int lat;
        tick(HP);
        load = 1'b1;
        commit_dev(0, cnt_n, last16(hist_n));
        commit_dev(1, cnt_f, last16(hist_f));
        cnt_n = 0;
        cnt_f = 0;
        lat = 0;
        do begin
            tick(1);
            lat++;
        end while (!n_valid && lat < 20);
        chk("commit latency", lat, SYNC + 1);
        tick(HP);
        load = 1'b0;
        tick(HP);
    endtask

    task automatic frame(input logic [15:0] w);
        send_word({16'h0, w}, 16);
        do_load();
    endtask

    task automatic check_out(input int d);
        exp_t  e;
        string p;
        p = (d == 0) ? "near" : "far";
        if ((d == 0 && q_near.size() == 0) || (d == 1 && q_far.size() == 0)) begin
            chk({p, " unexpected frame_valid"}, 1, 0);
        end else begin
            e = (d == 0) ? q_near.pop_front() : q_far.pop_front();
            chk({p, " addr"},  d ? f_addr  : n_addr,  e.addr);
            chk({p, " data"},  d ? f_data  : n_data,  e.data);
            chk({p, " err"},   d ? f_err   : n_err,   e.err);
            chk({p, " digits"}, d ? f_dig  : n_dig,   e.dig);
            chk({p, " decode"}, d ? f_dec  : n_dec,   e.dec);
            chk({p, " intensity"}, d ? f_inten : n_inten, e.inten);
            chk({p, " scan"},  d ? f_scan  : n_scan,  e.scan);
            chk({p, " shutdown_n"}, d ? f_shdn : n_shdn, e.shdn);
            chk({p, " display_test"}, d ? f_dtest : n_dtest, e.dtest);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            if (n_valid || f_valid) chk("frame_valid during reset", 1, 0);
        end else begin
            if (n_valid) check_out(0);
            if (f_valid) check_out(1);
        end
    end

    initial begin
        int guard;
        int n;
        logic [31:0] w;

        rst_n = 1'b0;
        model_reset();
        tick(5);
        chk("reset valid", n_valid, 0);
        chk("reset addr", n_addr, 0);
        chk("reset data", n_data, 0);
        chk("reset err", n_err, 0);
        chk("reset digits", n_dig, 0);
        chk("reset decode", n_dec, 0);
        chk("reset intensity", n_inten, 0);
        chk("reset scan", n_scan, 0);
        chk("reset shutdown_n", n_shdn, 0);
        chk("reset display_test", n_dtest, 0);
        chk("reset dout", n_dout, 0);
        rst_n = 1'b1;
        tick(5);

        frame(16'h0C01);
        chk("shutdown_n after 0x0C01", n_shdn, 1);

        frame(16'h0155);
        frame(16'h08AA);
        frame(16'h0A0F);
        frame(16'h0B07);
        chk("digit0 after 0x0155", n_dig[7:0], 8'h55);
        chk("digit7 after 0x08AA", n_dig[63:56], 8'hAA);
        chk("intensity after 0x0A0F", n_inten, 4'hF);
        chk("scan after 0x0B07", n_scan, 3'd7);

        send_word(32'h0F01_0933, 32);
        do_load();
        chk("cascade near decode", n_dec, 8'h33);
        chk("cascade far display_test", f_dtest, 1);
        chk("cascade near err", n_err, 0);
        chk("cascade far err", f_err, 0);

        send_word(32'h0000_02B5, 10);
        do_load();
        chk("short frame err", n_err, 1);

        frame(16'h0D7E);
        chk("addr 0xD pulse", n_addr, 4'hD);
        frame(16'h0000);
        chk("noop pulse", n_addr, 4'h0);
        frame(16'hF103);
        chk("upper nibble ignored digit0", n_dig[7:0], 8'h03);

        send_word(32'h0000_00A5, 8);
        din = 1'b0;
        rst_n = 1'b0;
        model_reset();
        tick(3);
        chk("near dout in reset", n_dout, 0);
        chk("far dout in reset", f_dout, 0);
        chk("intensity in reset", n_inten, 0);
        rst_n = 1'b1;
        tick(4);
        frame(16'h0A05);
        chk("intensity after reset frame", n_inten, 4'h5);

        for (int it = 0; it < 30; it++) begin
            w = $urandom;
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 28)) : 16;
            send_word(w, n);
            do_load();
        end

        guard = 0;
        while ((q_near.size() != 0 || q_far.size() != 0) && guard < 100) begin
            tick(1);
            guard++;
        end
        chk("scoreboard drained", q_near.size() + q_far.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_max7219_frame_rx
`default_nettype wire
